rr_mux_pipe: RTL and testbench

- Parametrised, registered N-to-1 multiplexer with valid/ready handshakes.
- Successor of the fixed 8-input combinational mux; one output register stage.
- Two modes:
  - Select mode: the channel index is driven by the control unit.
  - Round-robin mode: fair arbitration among requesting channels.
- Sits between multiple datapath producers (ALU, load unit, CSR/immediate sources) and a single consumer such as the writeback port.

---
 rtl/rr_mux_pipe_if.sv | 27 ++
 rtl/rr_mux_pipe.sv | 112 +++++++++++
 tb/tb_rr_mux_pipe.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/rr_mux_pipe_if.sv
// Handshake bundle between N producers and one consumer around rr_mux_pipe.
// The master side drives producer/consumer controls; the slave side is the mux.
interface rr_mux_pipe_if #(
    parameter int WIDTH  = 32,
    parameter int NUM_CH = 8,
    parameter int SEL_W  = 3
);
    logic                    mode;
    logic [SEL_W-1:0]        sel;
    logic [NUM_CH-1:0]       in_valid;
    logic [NUM_CH-1:0]       in_ready;
    logic [NUM_CH*WIDTH-1:0] in_data;
    logic                    out_valid;
    logic                    out_ready;
    logic [WIDTH-1:0]        out_data;
    logic [SEL_W-1:0]        out_ch;

    modport master (
        output mode, sel, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_ch
    );

    modport slave (
        input  mode, sel, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_ch
    );
endinterface

// File: rtl/rr_mux_pipe.sv
// Registered N-to-1 mux with valid/ready handshakes: either the control unit
// selects a channel, or a round-robin arbiter picks among requesters.
module rr_mux_pipe #(
    parameter int WIDTH  = 32,
    parameter int NUM_CH = 8,
    parameter int SEL_W  = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    rr_mux_pipe_if.slave bus
);
    logic              load_s;
    logic              grant_any_s;
    logic [SEL_W-1:0]  grant_idx_s;
    logic [NUM_CH-1:0] grant_s;
    logic [WIDTH-1:0]  grant_data_s;

    logic              out_valid_q, out_valid_d;
    logic [WIDTH-1:0]  out_data_q,  out_data_d;
    logic [SEL_W-1:0]  out_ch_q,    out_ch_d;
    logic [SEL_W-1:0]  last_grant_q, last_grant_d;

    // The output stage can accept a word when empty or draining this cycle.
    assign load_s = ~out_valid_q | bus.out_ready;

    // Winner selection; the rotating search wraps at NUM_CH-1 so non-power-of-two
    // channel counts never probe a channel that does not exist.
    always_comb begin
        int  pos;
        logic take;
        grant_any_s = 1'b0;
        grant_idx_s = {SEL_W{1'b0}};
        pos         = 0;
        take        = 1'b0;
        if (bus.mode == 1'b0) begin
            for (int i = 0; i < NUM_CH; i++) begin
                take        = (bus.sel == SEL_W'(i)) & bus.in_valid[i];
                grant_idx_s = take ? SEL_W'(i) : grant_idx_s;
                grant_any_s = grant_any_s | take;
            end
        end else begin
            for (int off = 1; off <= NUM_CH; off++) begin
                pos = int'(last_grant_q) + off;
                pos = (pos >= NUM_CH) ? (pos - NUM_CH) : pos;
                for (int i = 0; i < NUM_CH; i++) begin
                    take        = ~grant_any_s & (pos == i) & bus.in_valid[i];
                    grant_idx_s = take ? SEL_W'(i) : grant_idx_s;
                    grant_any_s = grant_any_s | take;
                end
            end
        end
    end

    // One-hot grant vector and AND-OR data mux of the winning channel.
    always_comb begin
        grant_s      = {NUM_CH{1'b0}};
        grant_data_s = {WIDTH{1'b0}};
        for (int i = 0; i < NUM_CH; i++) begin
            grant_s[i]   = grant_any_s & (grant_idx_s == SEL_W'(i));
            grant_data_s = grant_data_s
                         | ({WIDTH{grant_s[i]}} & bus.in_data[i*WIDTH +: WIDTH]);
        end
    end

    assign bus.in_ready = {NUM_CH{load_s}} & grant_s;

    // Next state of the output register and the round-robin pointer.
    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_ch_d     = out_ch_q;
        last_grant_d = last_grant_q;
        if (load_s) begin
            out_valid_d = grant_any_s;
            if (grant_any_s) begin
                out_data_d   = grant_data_s;
                out_ch_d     = grant_idx_s;
                // Select-mode transfers must not disturb round-robin fairness.
                last_grant_d = bus.mode ? grant_idx_s : last_grant_q;
            end else begin
                out_data_d   = out_data_q;
                out_ch_d     = out_ch_q;
                last_grant_d = last_grant_q;
            end
        end else begin
            out_valid_d  = out_valid_q;
            out_data_d   = out_data_q;
            out_ch_d     = out_ch_q;
            last_grant_d = last_grant_q;
        end
    end

    // Output register and pointer; the pointer resets to the last channel so
    // channel 0 wins the first round-robin arbitration.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= {WIDTH{1'b0}};
            out_ch_q     <= {SEL_W{1'b0}};
            last_grant_q <= SEL_W'(NUM_CH - 1);
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_ch_q     <= out_ch_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_ch    = out_ch_q;
endmodule

// File: tb/tb_rr_mux_pipe.sv
// Directed bench for rr_mux_pipe: an 8-channel instance for the main scenarios
// and a 6-channel instance for out-of-range select and non-power-of-two wrap.
module tb_rr_mux_pipe;
    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    rr_mux_pipe_if #(.WIDTH(32), .NUM_CH(8), .SEL_W(3)) b8 ();
    rr_mux_pipe_if #(.WIDTH(32), .NUM_CH(6), .SEL_W(3)) b6 ();

    rr_mux_pipe #(.WIDTH(32), .NUM_CH(8), .SEL_W(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b8)
    );

    rr_mux_pipe #(.WIDTH(32), .NUM_CH(6), .SEL_W(3)) dut6 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b6)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] pat(input int i);
        return 32'hC0DE_0000 | 32'(i);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        b8.mode = 1'b0; b8.sel = 3'd0; b8.in_valid = 8'h00; b8.out_ready = 1'b1;
        b6.mode = 1'b0; b6.sel = 3'd0; b6.in_valid = 6'h00; b6.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) b8.in_data[i*32 +: 32] = pat(i);
        for (int i = 0; i < 6; i++) b6.in_data[i*32 +: 32] = pat(i);

        // Reset state
        repeat (2) tick();
        chk("rst_valid", 32'(b8.out_valid), 32'd0);
        chk("rst_data",  b8.out_data,       32'd0);
        chk("rst_ch",    32'(b8.out_ch),    32'd0);
        #2 rst_n = 1'b1;
        tick();

        // 1: select mode, sel=5
        b8.mode = 1'b0; b8.sel = 3'd5; b8.in_valid = 8'h20;
        b8.in_data[5*32 +: 32] = 32'hDEAD_BEEF;
        #1 chk("t1_in_ready", 32'(b8.in_ready), 32'h20);
        tick();
        chk("t1_valid", 32'(b8.out_valid), 32'd1);
        chk("t1_data",  b8.out_data,       32'hDEAD_BEEF);
        chk("t1_ch",    32'(b8.out_ch),    32'd5);
        b8.in_valid = 8'h00;
        b8.in_data[5*32 +: 32] = pat(5);
        tick();
        chk("t1_drain", 32'(b8.out_valid), 32'd0);

        // 2: round-robin over all channels, one word per cycle
        b8.mode = 1'b1; b8.in_valid = 8'hFF;
        for (int k = 0; k < 9; k++) begin
            #1 chk("t2_in_ready", 32'(b8.in_ready), 32'(1) << (k % 8));
            tick();
            chk("t2_valid", 32'(b8.out_valid), 32'd1);
            chk("t2_ch",    32'(b8.out_ch),    32'(k % 8));
            chk("t2_data",  b8.out_data,       pat(k % 8));
        end

        // 3: backpressure with requesters 1 and 3 (pointer at 0)
        b8.in_valid = 8'h0A;
        #1 chk("t3_first_ready", 32'(b8.in_ready), 32'h02);
        tick();
        chk("t3_first_ch", 32'(b8.out_ch), 32'd1);
        b8.out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1 chk("t3_stall_ready", 32'(b8.in_ready), 32'h00);
            tick();
            chk("t3_stall_valid", 32'(b8.out_valid), 32'd1);
            chk("t3_stall_ch",    32'(b8.out_ch),    32'd1);
            chk("t3_stall_data",  b8.out_data,       pat(1));
        end
        b8.out_ready = 1'b1;
        #1 chk("t3_release_ready", 32'(b8.in_ready), 32'h08);
        tick();
        chk("t3_release_ch",   32'(b8.out_ch), 32'd3);
        chk("t3_release_data", b8.out_data,    pat(3));

        // 4: selected channel not valid -> no transfer, register drains
        b8.mode = 1'b0; b8.sel = 3'd2; b8.in_valid = 8'h01;
        #1 chk("t4_in_ready", 32'(b8.in_ready), 32'h00);
        tick();
        chk("t4_drained", 32'(b8.out_valid), 32'd0);
        b8.in_valid = 8'h00;

        // 4b: 6-channel instance, out-of-range select and wrap at channel 5
        b6.mode = 1'b0; b6.sel = 3'd7; b6.in_valid = 6'h3F;
        #1 chk("t4_n6_sel7_ready", 32'(b6.in_ready), 32'h00);
        tick();
        chk("t4_n6_sel7_valid", 32'(b6.out_valid), 32'd0);
        b6.mode = 1'b1; b6.in_valid = 6'h21;
        #1 chk("t4_n6_rr0_ready", 32'(b6.in_ready), 32'h01);
        tick();
        chk("t4_n6_rr0_ch", 32'(b6.out_ch), 32'd0);
        #1 chk("t4_n6_rr5_ready", 32'(b6.in_ready), 32'h20);
        tick();
        chk("t4_n6_rr5_ch",   32'(b6.out_ch), 32'd5);
        chk("t4_n6_rr5_data", b6.out_data,    pat(5));
        #1 chk("t4_n6_wrap_ready", 32'(b6.in_ready), 32'h01);
        tick();
        chk("t4_n6_wrap_ch", 32'(b6.out_ch), 32'd0);
        b6.in_valid = 6'h00;

        // 5: pointer survives select-mode transfers (pointer at 3 now)
        b8.mode = 1'b1; b8.in_valid = 8'h10;
        #1 chk("t5_rr4_ready", 32'(b8.in_ready), 32'h10);
        tick();
        chk("t5_rr4_ch", 32'(b8.out_ch), 32'd4);
        b8.mode = 1'b0; b8.sel = 3'd0; b8.in_valid = 8'h01;
        tick();
        chk("t5_sel0_a", 32'(b8.out_ch), 32'd0);
        tick();
        chk("t5_sel0_b", 32'(b8.out_ch), 32'd0);
        b8.mode = 1'b1; b8.in_valid = 8'h31;
        #1 chk("t5_resume_ready", 32'(b8.in_ready), 32'h20);
        tick();
        chk("t5_resume_ch", 32'(b8.out_ch), 32'd5);
        chk("t5_resume_valid", 32'(b8.out_valid), 32'd1);

        // 6: asynchronous reset between edges clears the held word at once
        #2 rst_n = 1'b0;
        #1;
        chk("t6_async_valid", 32'(b8.out_valid), 32'd0);
        chk("t6_async_data",  b8.out_data,       32'd0);
        chk("t6_async_ch",    32'(b8.out_ch),    32'd0);
        #2 rst_n = 1'b1;
        b8.mode = 1'b1; b8.in_valid = 8'h81;
        #1 chk("t6_post_ready", 32'(b8.in_ready), 32'h01);
        tick();
        chk("t6_post_ch",   32'(b8.out_ch), 32'd0);
        chk("t6_post_data", b8.out_data,    pat(0));
        #1 chk("t6_next_ready", 32'(b8.in_ready), 32'h80);
        tick();
        chk("t6_next_ch", 32'(b8.out_ch), 32'd7);
        b8.in_valid = 8'h00;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
